// File: rtl/srm_pkg.sv
// Shared definitions for the SRM control sequencer: state codes and control-word bit positions.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package srm_pkg;

  localparam int CTL_W = 15;

  // Control-word bit positions as produced by the instruction decoder
  localparam int CTL_C_WE    = 0;
  localparam int CTL_PC_JMP  = 2;
  localparam int CTL_SR_WE   = 3;
  localparam int CTL_MEM_WE  = 4;
  localparam int CTL_MEM_REQ = 14;

  // Sequencer states
  typedef logic [2:0] state_t;
  localparam state_t ST_IDLE   = 3'd0;
  localparam state_t ST_FETCH  = 3'd1;
  localparam state_t ST_DECODE = 3'd2;
  localparam state_t ST_MEM    = 3'd3;
  localparam state_t ST_EXEC   = 3'd4;

  // An instruction needs a data phase when it either reads or writes memory
  function automatic logic needs_mem(input logic [CTL_W-1:0] ctl);
    return ctl[CTL_MEM_REQ] | ctl[CTL_MEM_WE];
  endfunction

endpackage

// File: rtl/srm_int_sync.sv
// Interrupt synchroniser: SYNC_STAGES flop chain feeding a sticky pending flag with a clear input.
// Latency: SYNC_STAGES+1 cycles from a stable input level to pending=1.
// Backpressure: none; pending holds until clr, which wins over a same-cycle set.
module srm_int_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  input  logic clr,
  output logic pending
);

  logic [SYNC_STAGES-1:0] sync_q;

  // Metastability chain: bring the asynchronous level into the clock domain
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q[0] <= async_in;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  // Sticky pending flag; a clear is taken first so a still-high level re-arms it one cycle later
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending <= 1'b0;
    end else if (clr) begin
      pending <= 1'b0;
    end else if (sync_q[SYNC_STAGES-1]) begin
      pending <= 1'b1;
    end
  end

endmodule

// File: rtl/srm_sequencer.sv
// SRM control sequencer: IDLE -> FETCH -> DECODE -> [MEM] -> EXEC with a one-cycle commit strobe.
// Latency: 3 cycles minimum per non-memory instruction, 4 minimum with a data phase.
// Backpressure: FETCH and MEM hold mem_req until mem_ack; acks in other states are ignored.
module srm_sequencer #(
  parameter int IR_W        = 16,
  parameter int CTL_W       = srm_pkg::CTL_W,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  input  logic             int_en,
  input  logic             hw_int_async,
  input  logic             mem_ack,
  input  logic [IR_W-1:0]  mem_rdata,
  input  logic [CTL_W-1:0] ctl_in,
  output logic             mem_req,
  output logic             mem_fetch,
  output logic             mem_we,
  output logic [IR_W-1:0]  ir,
  output logic             dec_en,
  output logic             dec_int,
  output logic [CTL_W-1:0] ctl_q,
  output logic [IR_W-1:0]  load_data,
  output logic             commit,
  output logic             int_ack,
  output logic             busy
);

  import srm_pkg::*;

  state_t state;
  state_t state_nxt;
  logic   int_pending;
  logic   int_taken;

  srm_int_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_int_sync (
    .clk      (clk),
    .rst_n    (rst_n),
    .async_in (hw_int_async),
    .clr      (int_ack),
    .pending  (int_pending)
  );

  // Next-state selection; FETCH and MEM wait on the memory handshake, run is only sampled in IDLE/EXEC
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (run) state_nxt = ST_FETCH;
      ST_FETCH:  if (mem_ack) state_nxt = ST_DECODE;
      ST_DECODE: state_nxt = needs_mem(ctl_in) ? ST_MEM : ST_EXEC;
      ST_MEM:    if (mem_ack) state_nxt = ST_EXEC;
      ST_EXEC:   state_nxt = run ? ST_FETCH : ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // State register; reset abandons any outstanding request immediately
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Captures: IR on fetch ack, control word and interrupt decision in DECODE, read data on load ack
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ir        <= '0;
      ctl_q     <= '0;
      load_data <= '0;
      int_taken <= 1'b0;
    end else begin
      if (state == ST_FETCH && mem_ack) begin
        ir <= mem_rdata;
      end
      if (state == ST_DECODE) begin
        ctl_q     <= ctl_in;
        int_taken <= dec_int;
      end
      if (state == ST_MEM && mem_ack && !ctl_q[CTL_MEM_WE]) begin
        load_data <= mem_rdata;
      end
    end
  end

  // Strobes are pure functions of state so an asynchronous reset drops them at once
  assign mem_req   = (state == ST_FETCH) || (state == ST_MEM);
  assign mem_fetch = (state == ST_FETCH);
  assign mem_we    = (state == ST_MEM) && ctl_q[CTL_MEM_WE];
  assign dec_en    = (state == ST_DECODE);
  assign dec_int   = (state == ST_DECODE) && int_pending && int_en;
  assign commit    = (state == ST_EXEC);
  assign int_ack   = (state == ST_EXEC) && int_taken;
  assign busy      = (state != ST_IDLE);

endmodule

// File: tb/tb_srm_sequencer.sv
// Bench for srm_sequencer: drives memory/decoder side per instruction and checks every cycle.
// Expected phases come from instruction timing arithmetic; interrupts from a sampled-level history.
// Bench plays the memory, so every wait is a fixed number of cycles.
module tb_srm_sequencer;

  localparam int IR_W  = 16;
  localparam int CTL_W = 15;
  localparam int SYNC  = 2;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             run;
  logic             int_en;
  logic             hw_int_async;
  logic             mem_ack;
  logic [IR_W-1:0]  mem_rdata;
  logic [CTL_W-1:0] ctl_in;
  logic             mem_req;
  logic             mem_fetch;
  logic             mem_we;
  logic [IR_W-1:0]  ir;
  logic             dec_en;
  logic             dec_int;
  logic [CTL_W-1:0] ctl_q;
  logic [IR_W-1:0]  load_data;
  logic             commit;
  logic             int_ack;
  logic             busy;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference state: pending flag, history of hw_int samples at clock edges, last loaded data
  logic            pend_m;
  logic [SYNC-1:0] hist;
  logic [IR_W-1:0] exp_load;

  srm_sequencer #(
    .IR_W        (IR_W),
    .CTL_W       (CTL_W),
    .SYNC_STAGES (SYNC)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .run          (run),
    .int_en       (int_en),
    .hw_int_async (hw_int_async),
    .mem_ack      (mem_ack),
    .mem_rdata    (mem_rdata),
    .ctl_in       (ctl_in),
    .mem_req      (mem_req),
    .mem_fetch    (mem_fetch),
    .mem_we       (mem_we),
    .ir           (ir),
    .dec_en       (dec_en),
    .dec_int      (dec_int),
    .ctl_q        (ctl_q),
    .load_data    (load_data),
    .commit       (commit),
    .int_ack      (int_ack),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    pend_m = 1'b0;
    hist   = '0;
  endtask

  // One clock edge: the level seen by the pending flag is the hw_int sample from SYNC edges ago
  task automatic cycle_end(input logic exp_ack);
    logic lvl;
    @(posedge clk);
    lvl = hist[SYNC-1];
    if (exp_ack) pend_m = 1'b0;
    else if (lvl) pend_m = 1'b1;
    hist = {hist[SYNC-2:0], hw_int_async};
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk("idle_busy", busy, 0);
      chk("idle_req", mem_req, 0);
      chk("idle_commit", commit, 0);
      run          = 1'b0;
      hw_int_async = 1'b0;
      mem_ack      = 1'($urandom_range(0, 1));
      mem_rdata    = 16'($urandom);
      cycle_end(1'b0);
    end
  endtask

  task automatic start_run();
    @(negedge clk);
    chk("start_busy", busy, 0);
    run          = 1'b1;
    mem_ack      = 1'b0;
    hw_int_async = 1'b0;
    cycle_end(1'b0);
  endtask

  // One instruction starting in its first FETCH cycle.
  // fw: fetch wait cycles, dw: data-phase wait cycles, hw_ctl: 0 off / 1 high in MEM / 2 random,
  // en_ctl: 0/1 fixed int_en, 2 random per instruction.
  task automatic do_instr(input int fw, input logic [CTL_W-1:0] ctl, input int dw,
                          input logic [IR_W-1:0] fdat, input logic [IR_W-1:0] ddat,
                          input logic run_after, input int hw_ctl, input int en_ctl);
    logic is_mem, we, exp_int, exp_dint;
    logic ph_f, ph_d, ph_m, ph_e;
    int n;
    is_mem  = ctl[14] | ctl[4];
    we      = ctl[4];
    n       = fw + 3 + (is_mem ? dw + 1 : 0);
    exp_int = 1'b0;
    int_en  = (en_ctl == 2) ? 1'($urandom_range(0, 1)) : (en_ctl == 1);
    for (int k = 0; k < n; k++) begin
      ph_f = (k <= fw);
      ph_d = (k == fw + 1);
      ph_m = is_mem && (k >= fw + 2) && (k <= fw + 2 + dw);
      ph_e = (k == n - 1);
      @(negedge clk);
      exp_dint = ph_d & pend_m & int_en;
      if (ph_d) exp_int = exp_dint;
      chk("mem_req", mem_req, ph_f | ph_m);
      chk("mem_fetch", mem_fetch, ph_f);
      chk("mem_we", mem_we, ph_m & we);
      chk("dec_en", dec_en, ph_d);
      chk("dec_int", dec_int, exp_dint);
      chk("commit", commit, ph_e);
      chk("int_ack", int_ack, ph_e & exp_int);
      chk("busy", busy, 1);
      if (ph_d || ph_e) chk("ir", ir, fdat);
      if (ph_m || ph_e) chk("ctl_q", ctl_q, ctl);
      if (ph_e) begin
        if (is_mem && !we) exp_load = ddat;
        chk("load_data", load_data, exp_load);
      end
      mem_ack      = (ph_f && k == fw) || (ph_m && k == fw + 2 + dw);
      mem_rdata    = mem_ack ? (ph_f ? fdat : ddat) : 16'($urandom);
      ctl_in       = ph_d ? ctl : 15'($urandom);
      run          = ph_e ? run_after : 1'(k & 1);
      hw_int_async = (hw_ctl == 1) ? ph_m : (hw_ctl == 2) ? ($urandom_range(0, 3) == 0) : 1'b0;
      cycle_end(ph_e & exp_int);
    end
  endtask

  initial begin
    int fw, dw, r;
    logic [CTL_W-1:0] ctl;
    logic ra;

    rst_n = 1'b0; run = 1'b0; int_en = 1'b0; hw_int_async = 1'b0;
    mem_ack = 1'b0; mem_rdata = '0; ctl_in = '0;
    model_reset();
    exp_load = '0;
    #12;
    chk("rst_busy", busy, 0);
    chk("rst_req", mem_req, 0);
    chk("rst_commit", commit, 0);
    chk("rst_ir", ir, 0);
    chk("rst_ctl_q", ctl_q, 0);
    chk("rst_load", load_data, 0);
    @(negedge clk);
    rst_n = 1'b1;
    cycle_end(1'b0);

    // Directed: minimum non-memory, load with 4 wait cycles, store
    start_run();
    do_instr(0, 15'h0001, 0, 16'hA5A5, 16'h0000, 1'b1, 0, 0);
    do_instr(1, 15'h4000, 4, 16'h1111, 16'hBEEF, 1'b1, 0, 0);
    do_instr(0, 15'h0010, 1, 16'h2222, 16'h5555, 1'b1, 0, 0);

    // Interrupt raised during MEM, taken at the next DECODE
    do_instr(0, 15'h4000, 3, 16'h3333, 16'h6666, 1'b1, 1, 1);
    do_instr(0, 15'h0008, 0, 16'h4444, 16'h0000, 1'b1, 0, 1);
    // Same with interrupts disabled: pending must survive until enabled
    do_instr(0, 15'h4000, 3, 16'h5151, 16'h7777, 1'b1, 1, 0);
    do_instr(0, 15'h0004, 0, 16'h6161, 16'h0000, 1'b1, 0, 0);
    do_instr(0, 15'h0001, 0, 16'h7171, 16'h0000, 1'b0, 0, 1);
    idle_cycles(2);

    // run low during a waited fetch, then stray acks in IDLE
    start_run();
    do_instr(2, 15'h0002, 0, 16'h8181, 16'h0000, 1'b0, 0, 0);
    idle_cycles(4);

    // Reset in the middle of a data phase
    start_run();
    @(negedge clk);
    chk("rt_fetch", mem_fetch, 1);
    mem_ack = 1'b1; mem_rdata = 16'h1234; run = 1'b1;
    cycle_end(1'b0);
    @(negedge clk);
    chk("rt_dec", dec_en, 1);
    mem_ack = 1'b0; ctl_in = 15'h4000;
    cycle_end(1'b0);
    @(negedge clk);
    chk("rt_memreq", mem_req, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("rt_req_drop", mem_req, 0);
    chk("rt_busy", busy, 0);
    chk("rt_commit", commit, 0);
    model_reset();
    exp_load = '0;
    run = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rt_hold_commit", commit, 0);
      chk("rt_hold_req", mem_req, 0);
    end
    chk("rt_ir", ir, 0);
    chk("rt_ctl_q", ctl_q, 0);
    chk("rt_load", load_data, 0);
    rst_n = 1'b1;
    cycle_end(1'b0);

    // Randomized instruction stream
    start_run();
    for (int i = 0; i < 200; i++) begin
      fw  = $urandom_range(0, 3);
      dw  = $urandom_range(0, 3);
      r   = $urandom_range(0, 3);
      ctl = 15'($urandom) & 15'h3FEF;
      if (r == 1 || r == 3) ctl[14] = 1'b1;
      if (r == 2 || r == 3) ctl[4]  = 1'b1;
      ra  = ($urandom_range(0, 3) != 0);
      do_instr(fw, ctl, dw, 16'($urandom), 16'($urandom), ra, 2, 2);
      if (!ra) begin
        idle_cycles($urandom_range(0, 3));
        start_run();
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
